// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared mode encodings, state enum and error bit indices for ps_mode_ctrl
package ps_pkg;

    localparam logic [1:0] PS_MODE_PASS  = 2'd0;
    localparam logic [1:0] PS_MODE_SOBEL = 2'd1;
    localparam logic [1:0] PS_MODE_GAUSS = 2'd2;
    localparam logic [1:0] PS_MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        SWITCH = 2'd3
    } ps_state_e;

    localparam int PS_ERR_TIMEOUT = 0;
    localparam int PS_ERR_OVERRUN = 1;

    function automatic logic mode_valid(input logic [1:0] m);
        return m != PS_MODE_RSVD;
    endfunction

endpackage

// File: rtl/ps_frame_counter.sv
// rtl/ps_frame_counter.sv - modulo-MAX pixel counter with clear and wrap pulse
module ps_frame_counter #(
    parameter int MAX = 307200,
    parameter int W   = 19
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign o_wrap = i_inc && (o_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_cnt <= '0;
        end else if (i_inc) begin
            o_cnt <= o_wrap ? '0 : o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps_mode_ctrl.sv
// rtl/ps_mode_ctrl.sv - frame-synchronous filter mode controller; PS_MODE_CTRL_TIMEOUT_EN adds a drain watchdog
module ps_mode_ctrl
    import ps_pkg::*;
#(
    parameter int         FRAME_PIXELS   = 307200,
    parameter int         CNT_W          = 19,
    parameter int         FLUSH_CYCLES   = 4,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [1:0] RESET_MODE     = 2'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode_req,
    input  logic       i_mode_req_valid,
    input  logic       i_in_pix,
    input  logic       i_out_pix,
    input  logic       i_obuf_empty,
    input  logic       i_err_clr,
    output logic [1:0] o_mode,
    output logic       o_enable,
    output logic       o_flush,
    output logic       o_hold,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [1:0] o_err
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    if (FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 1 || FRAME_PIXELS < 2 ||
        (FRAME_PIXELS - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("ps_mode_ctrl: invalid parameter set");
    end

    ps_state_e        state, state_nxt;
    logic [1:0]       pend_mode, target, go_mode, err_set;
    logic             pend_v, req_ok, boundary_go, drain_exit, wd_expired;
    logic             out_done, cnt_clr, in_wrap, out_wrap;
    logic [CNT_W-1:0] unused_in_cnt, out_cnt;
    logic [FL_W-1:0]  flush_cnt;

    // Counters are cleared for the whole flush window so the new mode starts on a fresh frame.
    assign cnt_clr = (state_nxt == FLUSH);

    ps_frame_counter #(.MAX(FRAME_PIXELS), .W(CNT_W)) u_in_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(i_in_pix), .i_clr(cnt_clr),
        .o_cnt(unused_in_cnt), .o_wrap(in_wrap)
    );

    ps_frame_counter #(.MAX(FRAME_PIXELS), .W(CNT_W)) u_out_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(i_out_pix), .i_clr(cnt_clr),
        .o_cnt(out_cnt), .o_wrap(out_wrap)
    );

    // A same-cycle request takes effect at this boundary, overriding anything pending.
    assign req_ok      = i_mode_req_valid && mode_valid(i_mode_req) &&
                         (pend_v || (i_mode_req != o_mode));
    assign go_mode     = req_ok ? i_mode_req : pend_mode;
    assign boundary_go = (state == RUN) && in_wrap && (pend_v || req_ok);
    assign drain_exit  = (out_done && i_obuf_empty) || wd_expired;

`ifdef PS_MODE_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || (state != DRAIN)) wd_cnt <= '0;
        else                           wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (state == DRAIN) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    assign err_set[PS_ERR_TIMEOUT] = wd_expired;
    assign err_set[PS_ERR_OVERRUN] = i_in_pix && o_hold;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (boundary_go) state_nxt = DRAIN;
            DRAIN:   if (drain_exit) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) state_nxt = SWITCH;
            SWITCH:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= RUN;
            pend_v       <= 1'b0;
            pend_mode    <= RESET_MODE;
            target       <= RESET_MODE;
            o_mode       <= RESET_MODE;
            o_enable     <= (RESET_MODE != PS_MODE_PASS);
            flush_cnt    <= '0;
            out_done     <= 1'b0;
            o_flush      <= 1'b0;
            o_hold       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 2'b00;
        end else begin
            state <= state_nxt;
            if (boundary_go) begin
                target <= go_mode;
                pend_v <= 1'b0;
            end else if (req_ok) begin
                pend_mode <= i_mode_req;
                pend_v    <= 1'b1;
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            // Outside DRAIN this tracks "output frame complete at entry" for the next DRAIN.
            if (state == DRAIN) out_done <= out_done || out_wrap;
            else                out_done <= ((out_cnt == '0) && !i_out_pix) || out_wrap;
            if (state == SWITCH) begin
                o_mode   <= target;
                o_enable <= (target != PS_MODE_PASS);
            end
            o_flush      <= (state_nxt == FLUSH);
            o_hold       <= (state_nxt != RUN);
            o_busy       <= (state_nxt != RUN);
            o_frame_done <= out_wrap;
            o_err        <= (i_err_clr ? 2'b00 : o_err) | err_set;
        end
    end

endmodule
